// File: rtl/risc_trace_buffer.sv
// ---------------------------------------------------------------------------
// risc_trace_buffer
//
// Instruction-trace capture buffer for the RISC core. Retired
// {pc, instr, msb} tuples are written into a circular memory while a capture
// is running. Capture ends in one of three ways, selected by mode:
//   00 wrap       capture until stop; old entries are overwritten.
//   01 fill-stop  capture until the buffer is full.
//   10 trigger    capture until post_cnt samples follow the sample whose
//                 pc matches trig_pc.
//   11 reserved   arm clears the buffer and leaves it idle; no writes.
// Once capture has ended, entries are read back oldest-first through a
// registered read port.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   mode, arm, stop     capture control (priority: arm > stop > sample_en)
//   sample_en, pc_in,
//   instr_in, msb_in    retired-instruction sample from the core
//   trig_pc, post_cnt   trigger PC and post-trigger sample count (mode 10)
//   rd_en               pop the oldest entry (IDLE/DONE only)
//   rd_pc, rd_instr,
//   rd_msb, rd_valid    popped entry, one cycle after rd_en
//   count               stored entries, 0..DEPTH
//   state               00 IDLE, 01 CAPTURE, 10 POST, 11 DONE
//   triggered, overflow sticky status, cleared by arm or reset
//
// Read handshake: there is no ready/backpressure on either side. A pop is
// accepted on a clock edge where rd_en=1, count>0, no arm, and the state is
// IDLE or DONE. An accepted pop drives rd_valid=1 with the entry on rd_*
// for exactly the following cycle; otherwise rd_valid=0 and rd_* hold.
// ---------------------------------------------------------------------------
module risc_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              arm,
   input  logic              stop,
   input  logic              sample_en,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] instr_in,
   input  logic              msb_in,
   input  logic [DATA_W-1:0] trig_pc,
   input  logic [AW:0]       post_cnt,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_instr,
   output logic              rd_msb,
   output logic              rd_valid,
   output logic [AW:0]       count,
   output logic [1:0]        state,
   output logic              triggered,
   output logic              overflow
);

   localparam int EW = 2 * DATA_W + 1;

   localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW:0] FULL_M1 = (AW + 1)'(DEPTH - 1);
   localparam logic [AW:0] ONE     = (AW + 1)'(1);

   localparam logic [1:0] MODE_FILL = 2'b01;
   localparam logic [1:0] MODE_TRIG = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_CAPTURE = 2'b01,
      ST_POST    = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [AW:0]     remain_q, remain_d;
   logic            trig_q, trig_d;
   logic            ovf_q, ovf_d;
   logic            mem_we;
   logic            rd_fire;

   // Trace memory is deliberately not reset; count/pointers define validity.
   logic [EW-1:0]   mem [DEPTH];

   // ------------------------------------------------------------------------
   // Next-state / control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      remain_d = remain_q;
      trig_d   = trig_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;
      rd_fire  = 1'b0;

      if (arm) begin
         // arm restarts from any state and drops a coincident sample.
         state_d  = (mode == MODE_RSVD) ? ST_IDLE : ST_CAPTURE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         remain_d = '0;
         trig_d   = 1'b0;
         ovf_d    = 1'b0;
      end else if (state_q == ST_CAPTURE || state_q == ST_POST) begin
         if (sample_en && mode != MODE_RSVD) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL) begin
               // Buffer full: the write lands on the oldest entry, so the
               // read pointer moves past it and count stays at DEPTH.
               rd_ptr_d = rd_ptr_q + 1'b1;
               ovf_d    = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end

            if (state_q == ST_CAPTURE) begin
               if (mode == MODE_FILL && count_q == FULL_M1) begin
                  state_d = ST_DONE;
               end
               if (mode == MODE_TRIG && pc_in == trig_pc) begin
                  trig_d   = 1'b1;
                  remain_d = post_cnt;
                  state_d  = (post_cnt == '0) ? ST_DONE : ST_POST;
               end
            end else begin
               remain_d = remain_q - 1'b1;
               if (remain_q == ONE) begin
                  state_d = ST_DONE;
               end
            end
         end

         // stop ends the capture after any coincident sample is written.
         if (stop) begin
            state_d = ST_DONE;
         end
      end else if (rd_en && count_q != '0) begin
         rd_fire  = 1'b1;
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_q - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers and registered read port
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         remain_q <= '0;
         trig_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rd_valid <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
         rd_msb   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         remain_q <= remain_d;
         trig_q   <= trig_d;
         ovf_q    <= ovf_d;
         rd_valid <= rd_fire;
         if (rd_fire) begin
            {rd_pc, rd_instr, rd_msb} <= mem[rd_ptr_q];
         end
      end
   end

   // Reads and writes never share a cycle (reads only outside capture),
   // so no bypass is needed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= {pc_in, instr_in, msb_in};
      end
   end

   assign count     = count_q;
   assign state     = state_q;
   assign triggered = trig_q;
   assign overflow  = ovf_q;

endmodule
